// File: rtl/aud_loop_pkg.sv
// Shared types and constants for the loop playback reader.
package aud_loop_pkg;

  localparam int SAMPLE_W = 16;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RD   = 2'd2,
    S_OUT  = 2'd3
  } state_e;

endpackage

// File: rtl/aud_loop_reader_sat_add.sv
// Combinational 16+16 signed adder clamped to the 16-bit sample range.
// Zero latency; no flow control.
module aud_sat_add
  import aud_loop_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] a,
  input  logic signed [SAMPLE_W-1:0] b,
  output logic signed [SAMPLE_W-1:0] y
);

  logic signed [SAMPLE_W:0] sum;

  assign sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};

  // The two top bits disagree exactly when the result left the 16-bit range.
  always_comb begin
    y = sum[SAMPLE_W-1:0];
    if (sum[SAMPLE_W] != sum[SAMPLE_W-1]) begin
      y = sum[SAMPLE_W] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/aud_loop_reader.sv
// Loop playback: one async SRAM read per sample strobe, output READ_WAIT+1 cycles later; strobes during a read are dropped.
// Define AUD_LOOP_MIX_EN to sum the live sample with playback (saturating) and pass live audio through when idle.
module aud_loop_reader
  import aud_loop_pkg::*;
#(
  parameter int READ_WAIT = 2,
  parameter int ADDR_W    = 20
) (
  input  logic                       i_AUD_BCLK,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_stop,
  input  logic [ADDR_W-1:0]          i_len,
  input  logic                       i_valid,
  input  logic signed [SAMPLE_W-1:0] i_data,
  input  logic [SAMPLE_W-1:0]        i_SRAM_DQ,
  output logic [ADDR_W-1:0]          o_SRAM_ADDR,
  output logic                       o_SRAM_CE_N,
  output logic                       o_SRAM_OE_N,
  output logic                       o_SRAM_WE_N,
  output logic                       o_SRAM_LB_N,
  output logic                       o_SRAM_UB_N,
  output logic signed [SAMPLE_W-1:0] o_data,
  output logic                       o_valid,
  output logic                       o_busy,
  output logic                       o_wrap,
  output logic                       o_overrun
);

  localparam int WC_W = $clog2(READ_WAIT + 1);

  state_e                     state;
  logic [ADDR_W-1:0]          addr_r;
  logic [ADDR_W-1:0]          len_r;
  logic [WC_W-1:0]            wait_cnt;
  logic                       sram_sel_n;
  logic                       oe_n;
  logic                       last;
  logic signed [SAMPLE_W-1:0] rd_sample;
  logic signed [SAMPLE_W-1:0] idle_sample;

`ifdef AUD_LOOP_MIX_EN
  logic signed [SAMPLE_W-1:0] live_r;

  aud_sat_add u_sat_add (
    .a (live_r),
    .b (i_SRAM_DQ),
    .y (rd_sample)
  );

  assign idle_sample = i_data;
`else
  logic unused_live;

  assign unused_live = ^i_data;
  assign rd_sample   = i_SRAM_DQ;
  assign idle_sample = '0;
`endif

  assign last        = (addr_r == len_r - 1'b1);
  assign o_SRAM_ADDR = addr_r;
  assign o_SRAM_CE_N = sram_sel_n;
  assign o_SRAM_LB_N = sram_sel_n;
  assign o_SRAM_UB_N = sram_sel_n;
  assign o_SRAM_OE_N = oe_n;
  assign o_SRAM_WE_N = 1'b1;
  assign o_busy      = (state != S_IDLE);

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      addr_r     <= '0;
      len_r      <= '0;
      wait_cnt   <= '0;
      sram_sel_n <= 1'b1;
      oe_n       <= 1'b1;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_wrap     <= 1'b0;
      o_overrun  <= 1'b0;
`ifdef AUD_LOOP_MIX_EN
      live_r     <= '0;
`endif
    end else begin
      o_valid <= 1'b0;
      o_wrap  <= 1'b0;
      if (i_valid && (state == S_RD || state == S_OUT)) begin
        o_overrun <= 1'b1;
      end

      // Stop outranks start; both abandon whatever read is in flight.
      if (i_stop) begin
        state      <= S_IDLE;
        addr_r     <= '0;
        wait_cnt   <= '0;
        sram_sel_n <= 1'b1;
        oe_n       <= 1'b1;
        if (state == S_IDLE) begin
          o_valid <= i_valid;
          o_data  <= idle_sample;
        end
      end else if (i_start && (i_len != '0)) begin
        state      <= S_ARM;
        len_r      <= i_len;
        addr_r     <= '0;
        wait_cnt   <= '0;
        sram_sel_n <= 1'b0;
        oe_n       <= 1'b1;
        o_overrun  <= 1'b0;
        if (state == S_IDLE) begin
          o_valid <= i_valid;
          o_data  <= idle_sample;
        end
      end else begin
        case (state)
          S_IDLE: begin
            o_valid <= i_valid;
            o_data  <= idle_sample;
          end
          S_ARM: begin
            if (i_valid) begin
              state    <= S_RD;
              wait_cnt <= WC_W'(1);
              oe_n     <= 1'b0;
`ifdef AUD_LOOP_MIX_EN
              live_r   <= i_data;
`endif
            end
          end
          S_RD: begin
            if (wait_cnt == WC_W'(READ_WAIT)) begin
              state    <= S_OUT;
              wait_cnt <= '0;
              oe_n     <= 1'b1;
              o_data   <= rd_sample;
              o_valid  <= 1'b1;
              o_wrap   <= last;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          S_OUT: begin
            state  <= S_ARM;
            addr_r <= last ? '0 : addr_r + 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aud_loop_reader.sv
// Randomized scoreboard bench for aud_loop_reader against a cycle-level loop playback model.
module tb_aud_loop_reader;

  localparam int ADDR_W = 20;
  localparam int RW     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              i_start = 1'b0, i_stop = 1'b0, i_valid = 1'b0;
  logic [ADDR_W-1:0] i_len = '0;
  logic [15:0]       i_data = '0;
  logic [15:0]       sram_dq;
  logic [ADDR_W-1:0] sram_addr;
  logic              ce_n, oe_n, we_n, lb_n, ub_n;
  logic [15:0]       o_data;
  logic              o_valid, o_busy, o_wrap, o_overrun;

  logic [15:0] mem [16];

  typedef struct {
    int          due;
    logic [15:0] d;
    logic        w;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  bit m_busy = 0;
  bit m_ovr  = 0;
  int m_len  = 0;
  int m_pos  = 0;
  int m_last = -100;

  aud_loop_reader #(.READ_WAIT(RW), .ADDR_W(ADDR_W)) dut (
    .i_AUD_BCLK (clk),
    .i_rst_n    (rst_n),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_len      (i_len),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_SRAM_DQ  (sram_dq),
    .o_SRAM_ADDR(sram_addr),
    .o_SRAM_CE_N(ce_n),
    .o_SRAM_OE_N(oe_n),
    .o_SRAM_WE_N(we_n),
    .o_SRAM_LB_N(lb_n),
    .o_SRAM_UB_N(ub_n),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_wrap     (o_wrap),
    .o_overrun  (o_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Asynchronous SRAM: data only driven while selected and output-enabled.
  assign sram_dq = (!ce_n && !oe_n) ? mem[sram_addr[3:0]] : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  function automatic logic [15:0] idle_val(input logic [15:0] d);
`ifdef AUD_LOOP_MIX_EN
    return d;
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [15:0] play_val(input logic [15:0] d, input logic [15:0] s);
`ifdef AUD_LOOP_MIX_EN
    return sat16(d, s);
`else
    return s;
`endif
  endfunction

  task automatic purge(input int c);
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].due > c) sb.delete(i);
  endtask

  task automatic push(input int due, input logic [15:0] d, input logic w);
    exp_t e;
    e.due = due; e.d = d; e.w = w;
    sb.push_back(e);
  endtask

  // One cycle of stimulus; the model decides what the DUT must emit for it.
  task automatic step(input bit v, input bit st, input bit sp, input int len, input logic [15:0] d);
    int c;
    c = cyc;
    i_valid = v; i_start = st; i_stop = sp; i_len = len[ADDR_W-1:0]; i_data = d;
    if (sp) begin
      if (m_busy) begin purge(c); m_busy = 0; end
      else if (v) push(c + 1, idle_val(d), 1'b0);
    end else if (st && len != 0) begin
      if (m_busy) purge(c);
      else if (v) push(c + 1, idle_val(d), 1'b0);
      m_busy = 1; m_len = len; m_pos = 0; m_last = -100; m_ovr = 0;
    end else if (!m_busy) begin
      if (v) push(c + 1, idle_val(d), 1'b0);
    end else if (v) begin
      if (c >= m_last + RW + 2) begin
        push(c + RW + 1, play_val(d, mem[m_pos]), m_pos == m_len - 1);
        m_pos  = (m_pos + 1) % m_len;
        m_last = c;
      end else begin
        m_ovr = 1;
      end
    end
    @(posedge clk); #1;
    i_valid = 0; i_start = 0; i_stop = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 16'h0);
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, o_busy, m_busy);
    chk({tag, "_overrun"}, o_overrun, m_ovr);
    if (!m_busy) begin
      chk({tag, "_ce_n"}, ce_n, 1);
      chk({tag, "_oe_n"}, oe_n, 1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_addr"}, sram_addr, 0);
    chk({tag, "_ce_n"}, ce_n, 1);
    chk({tag, "_oe_n"}, oe_n, 1);
    chk({tag, "_we_n"}, we_n, 1);
    chk({tag, "_lb_n"}, lb_n, 1);
    chk({tag, "_ub_n"}, ub_n, 1);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_wrap"}, o_wrap, 0);
    chk({tag, "_overrun"}, o_overrun, 0);
  endtask

  // Monitor: every o_valid must match the oldest expected sample, on time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("missing_valid_due", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (o_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", o_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("valid_cycle", cyc, e.due);
          chk("data", o_data, e.d);
          chk("wrap", o_wrap, e.w);
        end
      end else if (o_wrap) begin
        chk("wrap_without_valid", o_wrap, 0);
      end
      if (!oe_n) chk("oe_without_ce", ce_n, 0);
      if (!we_n) chk("we_asserted", we_n, 1);
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'(i * 16'h0111);
    mem[0] = 16'h0100; mem[1] = 16'h0200; mem[2] = 16'h0300; mem[3] = 16'h0400;

    #1 rst_n = 0;
    #20 check_reset_vals("reset");
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    idle(2);

    // Four-sample loop, ten strobes: wraps on the 4th and 8th.
    step(0, 1, 0, 4, 16'h0);
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 0, 0, 16'h0);
      idle(4);
    end
    check_status("loop4");
    step(0, 0, 1, 0, 16'h0);
    check_status("loop4_stop");

    // Zero length start is ignored; strobes still pass straight through.
    step(0, 1, 0, 0, 16'h0);
    for (int k = 0; k < 4; k++) begin
      check_status("len0");
      step(k == 1, 0, 0, 0, 16'h1234);
    end

    // Stop while the read is in flight.
    step(0, 1, 0, 4, 16'h0);
    step(1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 16'h0);
    step(0, 0, 1, 0, 16'h0);
    check_status("stop_rd");
    idle(3);
    step(0, 1, 0, 4, 16'h0);
    step(1, 0, 0, 0, 16'h0);
    idle(5);

    // Back-to-back strobes: second is dropped and flagged; a new start clears it.
    step(1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 0, 16'h0);
    idle(4);
    check_status("overrun");
    step(0, 1, 0, 2, 16'h0);
    check_status("overrun_clear");

    // Single-sample loop: address 0 every time, wrap on every output.
    step(0, 1, 0, 1, 16'h0);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 16'h0);
      idle(4);
    end
    step(0, 0, 1, 0, 16'h0);

`ifdef AUD_LOOP_MIX_EN
    mem[0] = 16'h2000;
    step(0, 1, 0, 1, 16'h0);
    step(1, 0, 0, 0, 16'h7000);
    idle(5);
    mem[0] = 16'hA000;
    step(1, 0, 0, 0, 16'h9000);
    idle(5);
    step(0, 0, 1, 0, 16'h0);
    mem[0] = 16'h0100;
`endif

    // Asynchronous reset in the middle of a read.
    step(0, 1, 0, 4, 16'h0);
    step(1, 0, 0, 0, 16'h0); idle(4);
    step(1, 0, 0, 0, 16'h0); idle(4);
    step(1, 0, 0, 0, 16'h0);
    chk("oe_low_mid_read", oe_n, 0);
    #2 rst_n = 0;
    #1 check_reset_vals("async_reset");
    sb.delete();
    m_busy = 0; m_ovr = 0;
    @(posedge clk); #2 rst_n = 1;
    @(posedge clk); #1;
    step(0, 1, 0, 4, 16'h0);
    step(1, 0, 0, 0, 16'h0);
    idle(5);
    step(0, 0, 1, 0, 16'h0);

    // Randomized sessions: random contents, lengths, gaps, stops and restarts.
    for (int s = 0; s < 6; s++) begin
      int len;
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      len = (s == 0) ? 1 : int'($urandom_range(2, 7));
      step(0, 1, 0, len, 16'h0);
      for (int k = 0; k < 14; k++) begin
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) begin
          step(0, 0, 1, 0, 16'h0);
          idle(2);
          step(0, 1, 0, len, 16'h0);
        end else if (r == 1) begin
          step(0, 1, 0, len, 16'h0);
        end else begin
          idle(int'($urandom_range(0, 5)));
          step(1, 0, 0, 0, 16'($urandom));
        end
      end
      idle(5);
      check_status("rand");
      step(0, 0, 1, 0, 16'h0);
      idle(2);
    end

    idle(6);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
